s4ga_cfg_streamer: RTL

//  Transmit side of the s4ga LUT-config stream. Holds N LUT configs in a writable

---
 rtl/s4ga_cfg_streamer_if.sv | 42 ++++
 rtl/s4ga_cfg_streamer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/s4ga_cfg_streamer_if.sv
// rtl/s4ga_cfg_streamer_if.sv - host/stream bundle for the s4ga config streamer
// Purpose: groups the run control, config-memory write port and the s4ga
//   receiver drive pins into one bundle.
// Signals:
//   run, cfg_we, cfg_addr[N_W], cfg_wdata[CFG_W]   host -> streamer
//   sweep_limit[16] (only with S4GA_SWEEP_LIMIT_EN) host -> streamer
//   s4ga_si[SI_W], s4ga_rst, busy, lut_idx[N_W], sweep_done  streamer -> host/receiver
// Modports: master = host/loader side, slave = streamer side.
interface s4ga_cfg_streamer_if #(
  parameter int N_W   = 7,
  parameter int CFG_W = 72,
  parameter int SI_W  = 4
);
  logic             run;
  logic             cfg_we;
  logic [N_W-1:0]   cfg_addr;
  logic [CFG_W-1:0] cfg_wdata;
`ifdef S4GA_SWEEP_LIMIT_EN
  logic [15:0]      sweep_limit;
`endif
  logic [SI_W-1:0]  s4ga_si;
  logic             s4ga_rst;
  logic             busy;
  logic [N_W-1:0]   lut_idx;
  logic             sweep_done;

  modport master (
`ifdef S4GA_SWEEP_LIMIT_EN
    output sweep_limit,
`endif
    output run, cfg_we, cfg_addr, cfg_wdata,
    input  s4ga_si, s4ga_rst, busy, lut_idx, sweep_done
  );

  modport slave (
`ifdef S4GA_SWEEP_LIMIT_EN
    input  sweep_limit,
`endif
    input  run, cfg_we, cfg_addr, cfg_wdata,
    output s4ga_si, s4ga_rst, busy, lut_idx, sweep_done
  );
endinterface

// File: rtl/s4ga_cfg_streamer.sv
// rtl/s4ga_cfg_streamer.sv - transmit side of the s4ga LUT-config stream
// Purpose: holds N LUT configs in a writable memory and drives the s4ga
//   receiver: a reset burst of RST_CYCLES cycles, then back-to-back sweeps of
//   all N configs, SI_W bits per clock, MS segment first.
// Ports:
//   clk, rst_n (async active-low)
//   bus (s4ga_cfg_streamer_if.slave): run, cfg_we/cfg_addr/cfg_wdata in;
//     s4ga_si, s4ga_rst, busy, lut_idx, sweep_done out (all registered).
// Option: S4GA_SWEEP_LIMIT_EN adds bus.sweep_limit; nonzero value stops
//   streaming after that many sweeps and requires run to drop before restart.
module s4ga_cfg_streamer #(
  parameter int N          = 79,
  parameter int K          = 5,
  parameter int SI_W       = 4,
  parameter int RST_CYCLES = N + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  s4ga_cfg_streamer_if.slave bus
);
  localparam int N_W       = $clog2(N);
  localparam int IDX_SEGS  = (N_W + SI_W - 1) / SI_W;
  localparam int MASK_SEGS = ((1 << K) + SI_W - 1) / SI_W;
  localparam int LL        = K * IDX_SEGS + MASK_SEGS;
  localparam int CFG_W     = LL * SI_W;
  localparam int SEG_W     = $clog2(LL);
  localparam int RC_W      = $clog2(RST_CYCLES);

  localparam logic [N_W-1:0]   LAST_N   = N_W'(N - 1);
  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(LL - 1);
  localparam logic [SEG_W-1:0] PEN_SEG  = SEG_W'(LL - 2);
  localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RESET, STREAM} state_t;

  state_t           state;
  logic [CFG_W-1:0] mem [N];
  logic [CFG_W-1:0] shreg;
  logic [SEG_W-1:0] seg;
  logic [RC_W-1:0]  rst_cnt;
  logic [N_W-1:0]   next_lut;
  logic [N_W-1:0]   load_idx;
  logic [CFG_W-1:0] load_word;
  logic             start_ok;
  logic             limit_hit;
`ifdef S4GA_SWEEP_LIMIT_EN
  logic [15:0]      limit_r;
  logic [15:0]      sweep_cnt;
  logic             need_low;
`endif

  // Config memory has no reset; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && int'(bus.cfg_addr) < N)
      mem[bus.cfg_addr] <= bus.cfg_wdata;
  end

  // Single read port: LUT 0 when leaving RESET, else the LUT after the current one.
  // Read shares the edge with the write, so a same-edge write sends the old word.
  always_comb begin
    next_lut  = (bus.lut_idx == LAST_N) ? '0 : bus.lut_idx + 1'b1;
    load_idx  = (state == STREAM) ? next_lut : '0;
    load_word = mem[load_idx];
  end

  always_comb begin
    start_ok  = bus.run;
    limit_hit = 1'b0;
`ifdef S4GA_SWEEP_LIMIT_EN
    start_ok  = bus.run && !need_low;
    limit_hit = (limit_r != 16'd0) && (sweep_cnt + 16'd1 == limit_r);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.s4ga_rst   <= 1'b1;
      bus.s4ga_si    <= '0;
      bus.busy       <= 1'b0;
      bus.lut_idx    <= '0;
      bus.sweep_done <= 1'b0;
      seg            <= '0;
      rst_cnt        <= '0;
      shreg          <= '0;
`ifdef S4GA_SWEEP_LIMIT_EN
      limit_r        <= '0;
      sweep_cnt      <= '0;
      need_low       <= 1'b0;
`endif
    end else begin
      bus.sweep_done <= 1'b0;
      case (state)
        IDLE: begin
`ifdef S4GA_SWEEP_LIMIT_EN
          if (!bus.run) need_low <= 1'b0;
`endif
          if (start_ok) begin
            state    <= RESET;
            bus.busy <= 1'b1;
            rst_cnt  <= '0;
`ifdef S4GA_SWEEP_LIMIT_EN
            limit_r   <= bus.sweep_limit;
            sweep_cnt <= '0;
`endif
          end
        end
        RESET: begin
          if (!bus.run) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (rst_cnt == LAST_RC) begin
            state        <= STREAM;
            bus.s4ga_rst <= 1'b0;
            bus.lut_idx  <= '0;
            seg          <= '0;
            bus.s4ga_si  <= load_word[CFG_W-1 -: SI_W];
            shreg        <= load_word << SI_W;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        STREAM: begin
          if (seg == LAST_SEG) begin
            // run (and the sweep limit) only matter at the sweep boundary
            if (bus.lut_idx == LAST_N && (!bus.run || limit_hit)) begin
              state        <= IDLE;
              bus.s4ga_rst <= 1'b1;
              bus.s4ga_si  <= '0;
              bus.busy     <= 1'b0;
              bus.lut_idx  <= '0;
              seg          <= '0;
`ifdef S4GA_SWEEP_LIMIT_EN
              need_low     <= limit_hit;
`endif
            end else begin
              bus.lut_idx <= next_lut;
              seg         <= '0;
              bus.s4ga_si <= load_word[CFG_W-1 -: SI_W];
              shreg       <= load_word << SI_W;
`ifdef S4GA_SWEEP_LIMIT_EN
              if (bus.lut_idx == LAST_N) sweep_cnt <= sweep_cnt + 16'd1;
`endif
            end
          end else begin
            seg         <= seg + 1'b1;
            bus.s4ga_si <= shreg[CFG_W-1 -: SI_W];
            shreg       <= shreg << SI_W;
            // registered so the pulse lines up with the final segment of LUT N-1
            if (bus.lut_idx == LAST_N && seg == PEN_SEG) bus.sweep_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
